hood_mode_scheduler: RTL and testbench

Central mode sequencer for the kitchen exhaust hood. It accepts one-cycle mode-change request pulses from the per-mode toggle controllers, arbitrates simultaneous requests by fixed priority, enforces the legal mode graph, runs the timed modes (hurricane, hurricane exit, self-clean) from a one-second prescaler, and drives the `current_mode` bus consumed by every mode controller, the fan driver and the display.

---
 rtl/hood_mode_scheduler.sv | 237 +++++++++++++++++++++++
 tb/tb_hood_mode_scheduler.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hood_mode_scheduler.sv
// Purpose : central kitchen-hood mode sequencer. It arbitrates request pulses, enforces the mode graph and times the hurricane and self-clean modes.
// Latency : a request sampled at edge T updates current_mode at edge T, and the new value is visible from T+1. Timed modes exit N*CLK_FREQ cycles after entry.
// Backpress: none. A request that is illegal or loses arbitration is dropped and is not queued.
//
// Ports:
//   clk, rstn            system clock; asynchronous active-low reset
//   power_on             debounced power switch level (low forces OFF)
//   req_standby/first/second/third/clean   single-cycle request pulses
//   current_mode         registered mode code: OFF=0 STANDBY=1 FIRST=2 SECOND=3 THIRD=4 CLEAN=5
//   countdown_sec        seconds remaining in a timed mode, else 0
//   third_locked         hurricane already used since this power-on
//   clean_done           one-cycle pulse after self-clean completes
//
// Build option: define SELF_CLEAN_EN to enable the CLEAN mode, req_clean and clean_done.
// When SELF_CLEAN_EN is undefined, req_clean is ignored and clean_done is held at 0.

module hood_mode_scheduler #(
   parameter int CLK_FREQ       = 100_000_000,
   parameter int THIRD_SECONDS  = 60,
   parameter int RETURN_SECONDS = 60,
   parameter int CLEAN_SECONDS  = 180,
   parameter int MODE_WIDTH     = 3
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  power_on,
   input  logic                  req_standby,
   input  logic                  req_first,
   input  logic                  req_second,
   input  logic                  req_third,
   input  logic                  req_clean,
   output logic [MODE_WIDTH-1:0] current_mode,
   output logic [7:0]            countdown_sec,
   output logic                  third_locked,
   output logic                  clean_done
);

   localparam int PS_W = (CLK_FREQ > 2) ? $clog2(CLK_FREQ) : 1;

   localparam logic [MODE_WIDTH-1:0] MODE_OFF     = MODE_WIDTH'(0);
   localparam logic [MODE_WIDTH-1:0] MODE_STANDBY = MODE_WIDTH'(1);
   localparam logic [MODE_WIDTH-1:0] MODE_FIRST   = MODE_WIDTH'(2);
   localparam logic [MODE_WIDTH-1:0] MODE_SECOND  = MODE_WIDTH'(3);
   localparam logic [MODE_WIDTH-1:0] MODE_THIRD   = MODE_WIDTH'(4);
   localparam logic [MODE_WIDTH-1:0] MODE_CLEAN   = MODE_WIDTH'(5);

   typedef enum logic [2:0] {
      ST_OFF,
      ST_STANDBY,
      ST_FIRST,
      ST_SECOND,
      ST_THIRD,
      ST_THIRD_EXIT,
      ST_CLEAN
   } state_t;

   state_t            state_q, state_d;
   logic [PS_W-1:0]   ps_q;
   logic              tick;
   logic              expire;
   logic              third_ok;
   logic              clean_ok;
   logic              load_en;
   logic [7:0]        load_val;
   logic              clean_fin;
   logic              timed_q;

   // THIRD_EXIT is the run-down after hurricane. Outside the scheduler it still looks like THIRD.
   function automatic logic [MODE_WIDTH-1:0] mode_of(input state_t s);
      case (s)
         ST_STANDBY:    mode_of = MODE_STANDBY;
         ST_FIRST:      mode_of = MODE_FIRST;
         ST_SECOND:     mode_of = MODE_SECOND;
         ST_THIRD:      mode_of = MODE_THIRD;
         ST_THIRD_EXIT: mode_of = MODE_THIRD;
         ST_CLEAN:      mode_of = MODE_CLEAN;
         default:       mode_of = MODE_OFF;
      endcase
   endfunction

`ifdef SELF_CLEAN_EN
   assign clean_ok = req_clean;
`else
   // With self-clean compiled out, a clean request never reaches arbitration.
   // A clean+third pair therefore resolves to third.
   logic unused_clean;
   assign clean_ok     = 1'b0;
   assign unused_clean = req_clean | clean_fin;
`endif

   // A locked third request is dropped before arbitration, so lower-priority requests in the same cycle can still win.
   assign third_ok = req_third & ~third_locked;

   // The prescaler restarts at every state entry.
   // The first tick is therefore exactly CLK_FREQ cycles after entry.
   assign tick    = (ps_q == PS_W'(CLK_FREQ - 1));
   assign expire  = tick && (countdown_sec == 8'd1);
   assign timed_q = (state_q == ST_THIRD) || (state_q == ST_THIRD_EXIT) || (state_q == ST_CLEAN);

   // Next-state logic. Losing power overrides everything.
   // Within each state, legal requests are taken in the order clean > third > standby > second > first.
   always_comb begin
      state_d   = state_q;
      load_en   = 1'b0;
      load_val  = 8'd0;
      clean_fin = 1'b0;

      if (!power_on) begin
         state_d = ST_OFF;
      end else begin
         case (state_q)
            ST_OFF: begin
               state_d = ST_STANDBY;
            end

            ST_STANDBY: begin
               if (clean_ok) begin
                  state_d  = ST_CLEAN;
                  load_en  = 1'b1;
                  load_val = 8'(CLEAN_SECONDS);
               end else if (third_ok) begin
                  state_d  = ST_THIRD;
                  load_en  = 1'b1;
                  load_val = 8'(THIRD_SECONDS);
               end else if (req_second) begin
                  state_d = ST_SECOND;
               end else if (req_first) begin
                  state_d = ST_FIRST;
               end
            end

            // A request for the current speed falls through to the next candidate.
            // If there is no other candidate, the state holds.
            ST_FIRST: begin
               if (third_ok) begin
                  state_d  = ST_THIRD;
                  load_en  = 1'b1;
                  load_val = 8'(THIRD_SECONDS);
               end else if (req_standby) begin
                  state_d = ST_STANDBY;
               end else if (req_second) begin
                  state_d = ST_SECOND;
               end
            end

            ST_SECOND: begin
               if (third_ok) begin
                  state_d  = ST_THIRD;
                  load_en  = 1'b1;
                  load_val = 8'(THIRD_SECONDS);
               end else if (req_standby) begin
                  state_d = ST_STANDBY;
               end else if (req_first) begin
                  state_d = ST_FIRST;
               end
            end

            // When a standby request and expiry land in the same cycle, the standby request wins.
            // This keeps the run-down period.
            ST_THIRD: begin
               if (req_standby) begin
                  state_d  = ST_THIRD_EXIT;
                  load_en  = 1'b1;
                  load_val = 8'(RETURN_SECONDS);
               end else if (expire) begin
                  state_d = ST_SECOND;
               end
            end

            ST_THIRD_EXIT: begin
               if (expire) begin
                  state_d = ST_STANDBY;
               end
            end

            ST_CLEAN: begin
               if (expire) begin
                  state_d   = ST_STANDBY;
                  clean_fin = 1'b1;
               end
            end

            default: begin
               state_d = ST_OFF;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= ST_OFF;
         current_mode <= MODE_OFF;
      end else begin
         state_q      <= state_d;
         current_mode <= mode_of(state_d);
      end
   end

   // Countdown, prescaler and hurricane lock.
   // On a state change, the countdown takes the load value of the new state, which is 0 for untimed states.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ps_q          <= '0;
         countdown_sec <= 8'd0;
         third_locked  <= 1'b0;
      end else if (!power_on) begin
         ps_q          <= '0;
         countdown_sec <= 8'd0;
         third_locked  <= 1'b0;
      end else if (state_d != state_q) begin
         ps_q          <= '0;
         countdown_sec <= load_en ? load_val : 8'd0;
         if (state_d == ST_THIRD) begin
            third_locked <= 1'b1;
         end
      end else begin
         ps_q <= tick ? '0 : ps_q + PS_W'(1);
         if (tick && timed_q && (countdown_sec != 8'd0)) begin
            countdown_sec <= countdown_sec - 8'd1;
         end
      end
   end

`ifdef SELF_CLEAN_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         clean_done <= 1'b0;
      end else begin
         clean_done <= clean_fin;
      end
   end
`else
   assign clean_done = 1'b0;
`endif

endmodule

// File: tb/tb_hood_mode_scheduler.sv
// Directed bench for hood_mode_scheduler with CLK_FREQ=10, THIRD=3 s, RETURN=2 s and CLEAN=4 s.
// Inputs are driven 1 ns after a rising edge, and outputs are checked at the same point.
// Each step() therefore shows the result of exactly one more edge.

module tb_hood_mode_scheduler;

   localparam logic [4:0] P_FIRST   = 5'b00001;
   localparam logic [4:0] P_SECOND  = 5'b00010;
   localparam logic [4:0] P_STANDBY = 5'b00100;
   localparam logic [4:0] P_THIRD   = 5'b01000;
   localparam logic [4:0] P_CLEAN   = 5'b10000;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       power_on = 1'b0;
   logic       req_standby = 1'b0;
   logic       req_first = 1'b0;
   logic       req_second = 1'b0;
   logic       req_third = 1'b0;
   logic       req_clean = 1'b0;
   logic [2:0] current_mode;
   logic [7:0] countdown_sec;
   logic       third_locked;
   logic       clean_done;

   int n_tests = 0;
   int n_fail  = 0;

   hood_mode_scheduler #(
      .CLK_FREQ      (10),
      .THIRD_SECONDS (3),
      .RETURN_SECONDS(2),
      .CLEAN_SECONDS (4),
      .MODE_WIDTH    (3)
   ) dut (
      .clk          (clk),
      .rstn         (rstn),
      .power_on     (power_on),
      .req_standby  (req_standby),
      .req_first    (req_first),
      .req_second   (req_second),
      .req_third    (req_third),
      .req_clean    (req_clean),
      .current_mode (current_mode),
      .countdown_sec(countdown_sec),
      .third_locked (third_locked),
      .clean_done   (clean_done)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic [4:0] r);
      {req_clean, req_third, req_standby, req_second, req_first} = r;
      step(1);
      {req_clean, req_third, req_standby, req_second, req_first} = 5'b0;
   endtask

   task automatic power_cycle();
      power_on = 1'b0;
      step(1);
      check_eq("pc_off_mode", current_mode, 0);
      check_eq("pc_off_lock", third_locked, 0);
      check_eq("pc_off_cnt", countdown_sec, 0);
      power_on = 1'b1;
      step(1);
      check_eq("pc_on_mode", current_mode, 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // Reset values
      #2;
      check_eq("rst_mode", current_mode, 0);
      check_eq("rst_cnt", countdown_sec, 0);
      check_eq("rst_lock", third_locked, 0);
      check_eq("rst_done", clean_done, 0);
      step(2);
      rstn = 1'b1;
      power_on = 1'b1;
      check_eq("pwr_mode_before", current_mode, 0);
      step(1);
      check_eq("pwr_mode_standby", current_mode, 1);
      check_eq("pwr_lock", third_locked, 0);
      check_eq("pwr_cnt", countdown_sec, 0);

      // Fan speeds and the request graph
      pulse(P_FIRST);
      check_eq("first_mode", current_mode, 2);
      pulse(P_SECOND);
      check_eq("second_mode", current_mode, 3);
      pulse(P_CLEAN);
      check_eq("clean_in_second", current_mode, 3);
      pulse(P_SECOND);
      check_eq("self_req_second", current_mode, 3);
      pulse(P_FIRST | P_STANDBY);
      check_eq("prio_standby_first", current_mode, 1);
      pulse(P_FIRST | P_SECOND);
      check_eq("prio_second_first", current_mode, 3);
      pulse(P_STANDBY);
      check_eq("back_standby", current_mode, 1);

      // Hurricane full run: entry at edge E, then 3 -> 2 -> 1, then exit to SECOND at E+30
      pulse(P_THIRD);
      check_eq("third_mode", current_mode, 4);
      check_eq("third_cnt3", countdown_sec, 3);
      check_eq("third_lock", third_locked, 1);
      step(9);
      check_eq("third_cnt3_e9", countdown_sec, 3);
      step(1);
      check_eq("third_cnt2_e10", countdown_sec, 2);
      step(10);
      check_eq("third_cnt1_e20", countdown_sec, 1);
      step(9);
      check_eq("third_mode_e29", current_mode, 4);
      step(1);
      check_eq("third_exp_mode", current_mode, 3);
      check_eq("third_exp_cnt", countdown_sec, 0);
      pulse(P_THIRD);
      check_eq("third_locked_ign", current_mode, 3);
      check_eq("third_locked_flag", third_locked, 1);

      // Standby from THIRD: a 2 s run-down that ignores further requests
      power_cycle();
      pulse(P_THIRD);
      check_eq("t2_mode", current_mode, 4);
      step(5);
      pulse(P_STANDBY);
      check_eq("exit_mode", current_mode, 4);
      check_eq("exit_cnt", countdown_sec, 2);
      step(4);
      pulse(P_FIRST);
      check_eq("exit_ign_mode", current_mode, 4);
      check_eq("exit_ign_cnt", countdown_sec, 2);
      step(14);
      check_eq("exit_s19_mode", current_mode, 4);
      check_eq("exit_s19_cnt", countdown_sec, 1);
      step(1);
      check_eq("exit_done_mode", current_mode, 1);
      check_eq("exit_done_cnt", countdown_sec, 0);
      check_eq("exit_lock_held", third_locked, 1);

      // A standby request in the same cycle as THIRD expiry goes to the run-down
      power_cycle();
      pulse(P_THIRD);
      step(29);
      check_eq("race_cnt1", countdown_sec, 1);
      pulse(P_STANDBY);
      check_eq("race_mode", current_mode, 4);
      check_eq("race_cnt", countdown_sec, 2);
      step(19);
      check_eq("race_e19_mode", current_mode, 4);
      step(1);
      check_eq("race_end_mode", current_mode, 1);
      power_cycle();

`ifdef SELF_CLEAN_EN
      // Self-clean wins over third, runs 40 cycles and pulses clean_done once
      pulse(P_CLEAN | P_THIRD);
      check_eq("clean_mode", current_mode, 5);
      check_eq("clean_cnt", countdown_sec, 4);
      check_eq("clean_nolock", third_locked, 0);
      step(39);
      check_eq("clean_e39_mode", current_mode, 5);
      check_eq("clean_e39_cnt", countdown_sec, 1);
      check_eq("clean_e39_done", clean_done, 0);
      step(1);
      check_eq("clean_end_mode", current_mode, 1);
      check_eq("clean_end_done", clean_done, 1);
      check_eq("clean_end_cnt", countdown_sec, 0);
      step(1);
      check_eq("clean_done_1cyc", clean_done, 0);

      // Power drop in mid-clean
      pulse(P_CLEAN);
      step(20);
      check_eq("cpd_cnt2", countdown_sec, 2);
      power_on = 1'b0;
      step(1);
      check_eq("cpd_mode", current_mode, 0);
      check_eq("cpd_cnt", countdown_sec, 0);
      check_eq("cpd_done", clean_done, 0);
      step(25);
      check_eq("cpd_late_done", clean_done, 0);
      check_eq("cpd_late_mode", current_mode, 0);
      power_on = 1'b1;
      step(1);
      check_eq("cpd_restore", current_mode, 1);
`else
      // Without self-clean, a clean+third pair resolves to third
      pulse(P_CLEAN | P_THIRD);
      check_eq("noclean_mode", current_mode, 4);
      check_eq("noclean_cnt", countdown_sec, 3);
      check_eq("noclean_lock", third_locked, 1);
      check_eq("noclean_done", clean_done, 0);
      step(15);
      check_eq("tpd_cnt2", countdown_sec, 2);
      power_on = 1'b0;
      step(1);
      check_eq("tpd_mode", current_mode, 0);
      check_eq("tpd_cnt", countdown_sec, 0);
      check_eq("tpd_lock", third_locked, 0);
      power_on = 1'b1;
      step(1);
      check_eq("tpd_restore", current_mode, 1);
`endif

      // An asynchronous reset in mid-countdown clears the block immediately
      pulse(P_THIRD);
      check_eq("ar_third", current_mode, 4);
      step(5);
      rstn = 1'b0;
      #1;
      check_eq("ar_mode", current_mode, 0);
      check_eq("ar_cnt", countdown_sec, 0);
      check_eq("ar_lock", third_locked, 0);
      step(1);
      rstn = 1'b1;
      step(1);
      check_eq("ar_restart", current_mode, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
